// File: rtl/interrupt_scheduler_if.sv
// Handshake bundle between the CPU core and the interrupt scheduler.
// The master modport is the CPU side, and the slave modport is the scheduler side.
interface interrupt_scheduler_if #(
    parameter int PC_W   = 11,
    parameter int TIME_W = 16
);
    logic              halt_req;
    logic              quantum_set;
    logic [TIME_W-1:0] quantum_val;
    logic [PC_W-1:0]   pc_next;
    logic              int_ack;
    logic              int_ret;
    logic              irq;
    logic [PC_W-1:0]   irq_vector;
    logic [31:0]       int_cause;
    logic [PC_W-1:0]   saved_pc;
    logic              busy;

    modport master (
        output halt_req, quantum_set, quantum_val, pc_next, int_ack, int_ret,
        input  irq, irq_vector, int_cause, saved_pc, busy
    );

    modport slave (
        input  halt_req, quantum_set, quantum_val, pc_next, int_ack, int_ret,
        output irq, irq_vector, int_cause, saved_pc, busy
    );
endinterface

// File: rtl/interrupt_scheduler.sv
// Time-quantum and halt interrupt scheduler. The scheduler preempts the CPU when the quantum expires
// or when a halt instruction executes, and it holds the resume PC for the handler.
module interrupt_scheduler #(
    parameter int PC_W   = 11,
    parameter int TIME_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    interrupt_scheduler_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, PENDING, SERVICE} state_t;

    localparam logic [31:0] CAUSE_NONE    = 32'd0;
    localparam logic [31:0] CAUSE_QUANTUM = 32'd1;
    localparam logic [31:0] CAUSE_HALT    = 32'd2;

    state_t            state;
    logic [TIME_W-1:0] cnt;
    logic [TIME_W-1:0] rld;
    logic              halt_pend;
    logic              irq_q;
    logic [31:0]       cause_q;
    logic [PC_W-1:0]   saved_q;

    logic              expire;
    logic [TIME_W-1:0] rld_eff;

    assign expire  = (state == RUN) && (cnt == TIME_W'(1));
    // A reload in the same cycle as int_ret takes effect immediately.
    assign rld_eff = bus.quantum_set ? bus.quantum_val : rld;

    // NOTE: all state is updated with non-blocking assignments, so every branch sees the pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rld       <= '0;
            halt_pend <= 1'b0;
            irq_q     <= 1'b0;
            cause_q   <= CAUSE_NONE;
            saved_q   <= '0;
        end else begin
            irq_q <= 1'b0;
            if (bus.quantum_set) begin
                cnt <= bus.quantum_val;
                rld <= bus.quantum_val;
            end

            case (state)
                IDLE, RUN: begin
                    // A halt beats a simultaneous expiry, and the expiry is dropped.
                    if (bus.halt_req || expire) begin
                        saved_q <= bus.pc_next;
                        cause_q <= bus.halt_req ? CAUSE_HALT : CAUSE_QUANTUM;
                        irq_q   <= 1'b1;
                        state   <= PENDING;
                    end else if (bus.quantum_set) begin
                        state <= (bus.quantum_val != '0) ? RUN : IDLE;
                    end else if (state == RUN) begin
                        cnt <= cnt - TIME_W'(1);
                    end
                end

                PENDING: begin
                    if (bus.halt_req) halt_pend <= 1'b1;
                    if (bus.int_ack) begin
                        cause_q <= CAUSE_NONE;
                        state   <= SERVICE;
                    end
                end

                SERVICE: begin
                    if (bus.int_ret) begin
                        if (halt_pend || bus.halt_req) begin
                            halt_pend <= 1'b0;
                            saved_q   <= bus.pc_next;
                            cause_q   <= CAUSE_HALT;
                            irq_q     <= 1'b1;
                            state     <= PENDING;
                        end else begin
                            cnt   <= rld_eff;
                            state <= (rld_eff != '0) ? RUN : IDLE;
                        end
                    end else if (bus.halt_req) begin
                        halt_pend <= 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.irq        = irq_q;
    assign bus.irq_vector = '0;
    assign bus.int_cause  = cause_q;
    assign bus.saved_pc   = saved_q;
    assign bus.busy       = (state == PENDING) || (state == SERVICE);
endmodule

// File: tb/tb_interrupt_scheduler.sv
// Self-checking bench for interrupt_scheduler. It runs directed vectors and corner sequences,
// then runs random traffic against a deadline-based reference model.
module tb_interrupt_scheduler;
    localparam int PC_W   = 11;
    localparam int TIME_W = 16;

    logic clk;
    logic rst;
    interrupt_scheduler_if #(.PC_W(PC_W), .TIME_W(TIME_W)) bus ();

    interrupt_scheduler #(.PC_W(PC_W), .TIME_W(TIME_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return 64'({bus.irq, bus.irq_vector, bus.int_cause, bus.saved_pc, bus.busy});
    endfunction

    function automatic logic [63:0] pack(input logic irq, input logic [31:0] cause,
                                         input logic [PC_W-1:0] saved, input logic busy);
        return 64'({irq, {PC_W{1'b0}}, cause, saved, busy});
    endfunction

    // Reference model. The timer is tracked as an absolute deadline (an edge index), not as a counter.
    int              now;
    bit              m_busy, m_acked, m_run, m_hdef, m_irq;
    int              m_cause, m_deadline, m_period;
    logic [PC_W-1:0] m_saved;

    function automatic void m_take(input int c);
        m_busy  = 1; m_acked = 0; m_cause = c;
        m_saved = bus.pc_next; m_irq = 1; m_run = 0;
    endfunction

    function automatic void model_edge();
        bit expiry;
        m_irq = 0;
        if (rst) begin
            m_busy = 0; m_acked = 0; m_run = 0; m_hdef = 0;
            m_cause = 0; m_period = 0; m_saved = '0;
        end else if (!m_busy) begin
            expiry = m_run && (now == m_deadline);
            if (bus.quantum_set) begin
                m_period   = int'(bus.quantum_val);
                m_run      = (m_period != 0);
                m_deadline = now + m_period;
            end
            if (bus.halt_req) m_take(2);
            else if (expiry)  m_take(1);
        end else begin
            if (bus.quantum_set) m_period = int'(bus.quantum_val);
            if (!m_acked) begin
                if (bus.halt_req) m_hdef = 1;
                if (bus.int_ack) begin m_acked = 1; m_cause = 0; end
            end else if (bus.int_ret) begin
                if (m_hdef || bus.halt_req) begin
                    m_hdef = 0;
                    m_take(2);
                end else begin
                    m_busy     = 0;
                    m_run      = (m_period != 0);
                    m_deadline = now + m_period;
                end
            end else if (bus.halt_req) begin
                m_hdef = 1;
            end
        end
        now++;
    endfunction

    task automatic drive(input logic r, input logic h, input logic qs, input int qv,
                         input int pc, input logic a, input logic rt);
        rst             = r;
        bus.halt_req    = h;
        bus.quantum_set = qs;
        bus.quantum_val = TIME_W'(qv);
        bus.pc_next     = PC_W'(pc);
        bus.int_ack     = a;
        bus.int_ret     = rt;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    typedef struct {
        logic            rst, halt, qs;
        int              qv, pc;
        logic            ack, ret;
        logic            irq;
        logic [31:0]     cause;
        logic [PC_W-1:0] saved;
        logic            busy;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic h, input logic qs, input int qv, input int pc,
                       input logic a, input logic rt, input logic i, input int c, input int s,
                       input logic b);
        vec_t v;
        v.rst = r; v.halt = h; v.qs = qs; v.qv = qv; v.pc = pc; v.ack = a; v.ret = rt;
        v.irq = i; v.cause = 32'(c); v.saved = PC_W'(s); v.busy = b;
        vq.push_back(v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int irq_seen;
        drive(1, 0, 0, 0, 0, 0, 0);
        now = 0;

        //   rst h qs qv  pc    ack ret | irq cause saved busy
        add(1, 0, 0, 0, 0,    0, 0,   0, 0, 'h00, 0);
        add(0, 0, 1, 3, 0,    0, 0,   0, 0, 'h00, 0);
        add(0, 0, 0, 0, 0,    0, 1,   0, 0, 'h00, 0);
        add(0, 0, 0, 0, 0,    1, 0,   0, 0, 'h00, 0);
        add(0, 0, 0, 0, 'h2A, 0, 0,   1, 1, 'h2A, 1);
        add(0, 0, 0, 0, 0,    0, 0,   0, 1, 'h2A, 1);
        add(0, 0, 0, 0, 0,    1, 0,   0, 0, 'h2A, 1);
        add(0, 0, 0, 0, 'h55, 0, 1,   0, 0, 'h2A, 0);
        add(0, 0, 0, 0, 0,    0, 0,   0, 0, 'h2A, 0);
        add(0, 0, 0, 0, 0,    0, 0,   0, 0, 'h2A, 0);
        add(0, 0, 0, 0, 'h33, 0, 0,   1, 1, 'h33, 1);
        add(0, 0, 0, 0, 0,    1, 0,   0, 0, 'h33, 1);
        add(0, 0, 0, 0, 0,    0, 1,   0, 0, 'h33, 0);
        add(0, 0, 0, 0, 0,    0, 0,   0, 0, 'h33, 0);
        add(0, 0, 0, 0, 0,    0, 0,   0, 0, 'h33, 0);
        add(0, 1, 0, 0, 'h44, 0, 0,   1, 2, 'h44, 1);
        add(0, 0, 0, 0, 0,    0, 0,   0, 2, 'h44, 1);
        add(0, 0, 0, 0, 0,    1, 0,   0, 0, 'h44, 1);
        add(0, 1, 0, 0, 'h77, 0, 0,   0, 0, 'h44, 1);
        add(0, 0, 0, 0, 0,    0, 0,   0, 0, 'h44, 1);
        add(0, 0, 0, 0, 'h10, 0, 1,   1, 2, 'h10, 1);
        add(0, 0, 0, 0, 0,    1, 1,   0, 0, 'h10, 1);
        add(0, 0, 0, 0, 'h66, 0, 1,   0, 0, 'h10, 0);
        add(0, 0, 1, 0, 0,    0, 0,   0, 0, 'h10, 0);

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].rst, vq[i].halt, vq[i].qs, vq[i].qv, vq[i].pc, vq[i].ack, vq[i].ret);
            step();
            check($sformatf("vec%0d", i), outs(),
                  pack(vq[i].irq, vq[i].cause, vq[i].saved, vq[i].busy));
        end

        // A disabled timer must stay silent.
        drive(0, 0, 0, 0, 0, 0, 0);
        irq_seen = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (bus.irq) irq_seen++;
        end
        check("disabled_no_irq", 64'(irq_seen), 64'd0);

        // A reset applied while in PENDING must clear all outputs, with no irq afterwards.
        drive(0, 0, 1, 2, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 'h5, 0, 0);
        step();
        drive(0, 0, 0, 0, 'h3C, 0, 0);
        step();
        check("expiry_q2", outs(), pack(1, 1, 'h3C, 1));
        drive(1, 0, 0, 0, 'h7F, 0, 0);
        step();
        check("rst_in_pending", outs(), 64'd0);
        drive(0, 0, 0, 0, 'h7F, 0, 0);
        irq_seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (outs() != 64'd0) irq_seen++;
        end
        check("after_rst_quiet", 64'(irq_seen), 64'd0);

        // Random traffic compared against the reference model.
        drive(1, 0, 0, 0, 0, 0, 0);
        step();
        for (int i = 0; i < 4000; i++) begin
            drive(($urandom_range(0, 299) == 0),
                  ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 9) == 0),
                  int'($urandom_range(0, 7)),
                  int'($urandom_range(0, (1 << PC_W) - 1)),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 3) == 0));
            step();
            check($sformatf("rand%0d", i), outs(),
                  pack(m_irq, 32'(m_cause), m_saved, m_busy));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/interrupt_scheduler.md
INTERRUPT_SCHEDULER -- requirements
Module: interrupt_scheduler

Interface
REQ-001 SHALL have parameter PC_W, default 11, instruction-address width.
REQ-002 SHALL have parameter TIME_W, default 16, quantum counter width.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port halt_req, input, 1, halt instruction executing this cycle.
REQ-006 SHALL have port quantum_set, input, 1, load new time quantum (setClock).
REQ-007 SHALL have port quantum_val, input, TIME_W, quantum length in cycles (instruction immediate).
REQ-008 SHALL have port pc_next, input, PC_W, PC value the CPU would load at this edge.
REQ-009 SHALL have port int_ack, input, 1, handler read the cause (getInterruption).
REQ-010 SHALL have port int_ret, input, 1, handler finished; resume preempted context.
REQ-011 SHALL have port irq, output, 1, one-cycle request forcing the PC to the vector.
REQ-012 SHALL have port irq_vector, output, PC_W, handler address; constant 0.
REQ-013 SHALL have port int_cause, output, 32, 0 none, 1 quantum expiry, 2 halt.
REQ-014 SHALL have port saved_pc, output, PC_W, captured resume address (feeds the PC buffer).
REQ-015 SHALL have port busy, output, 1, high in PENDING or SERVICE.

Function
REQ-016 SHALL implement states IDLE, RUN, PENDING and SERVICE.
REQ-017 SHALL hold a TIME_W down-counter cnt and a TIME_W reload register rld.
REQ-018 In IDLE/RUN, quantum_set with quantum_val != 0 SHALL load cnt and rld with quantum_val and enter RUN; quantum_val == 0 SHALL clear both and enter IDLE.
REQ-019 In RUN, cnt SHALL decrement by 1 per cycle; at cnt == 1 the next edge SHALL capture saved_pc <= pc_next, set int_cause = 1, pulse irq and enter PENDING, so expiry occurs N edges after a load of N.
REQ-020 In IDLE/RUN, halt_req SHALL capture saved_pc <= pc_next, set int_cause = 2, pulse irq and enter PENDING; cnt keeps its value.
REQ-021 When halt_req and expiry coincide, halt SHALL win (int_cause = 2), and the expiry SHALL be dropped.
REQ-022 When quantum_set coincides with halt_req or expiry, the interrupt SHALL be taken and the load SHALL still update cnt/rld.
REQ-023 irq SHALL be registered, high for exactly the one cycle following the entry edge into PENDING; irq_vector SHALL be 0 always.
REQ-024 In PENDING, int_cause SHALL hold; int_ack SHALL clear int_cause to 0 and enter SERVICE.
REQ-025 In PENDING/SERVICE, cnt SHALL be frozen; quantum_set SHALL update cnt/rld without leaving the state.
REQ-026 halt_req in PENDING/SERVICE SHALL set a sticky halt_pend bit and SHALL NOT alter saved_pc.
REQ-027 In SERVICE, int_ret with halt_pend set SHALL clear halt_pend, capture saved_pc <= pc_next, set int_cause = 2, pulse irq and re-enter PENDING.
REQ-028 In SERVICE, int_ret without halt_pend SHALL reload cnt <= rld and enter RUN if rld != 0, otherwise enter IDLE.
REQ-029 int_ack outside PENDING and int_ret outside SERVICE SHALL be ignored; int_ack and int_ret together in PENDING SHALL act as int_ack only.
REQ-030 saved_pc SHALL hold its value between captures.

Reset
REQ-031 rst SHALL force state IDLE, cnt = 0, rld = 0, halt_pend = 0, irq = 0, int_cause = 0, saved_pc = 0; busy = 0.
REQ-032 rst SHALL take priority over every other input, including mid-PENDING or SERVICE; no irq SHALL follow reset.

Verification
REQ-033 Quantum: quantum_set, quantum_val = 3, pc_next = 0x2A at the expiry edge -> irq high exactly one cycle, 3 edges after the load; int_cause = 1; saved_pc = 0x2A; busy = 1.
REQ-034 Handshake: after REQ-033, int_ack -> int_cause = 0, state SERVICE; int_ret -> cnt = 3, RUN, next irq 3 edges later.
REQ-035 Collision: halt_req on the expiry edge -> a single irq, int_cause = 2.
REQ-036 Deferred halt: halt_req during SERVICE, pc_next = 0x10 at the int_ret edge -> no irq until int_ret, then irq, int_cause = 2, saved_pc = 0x10.
REQ-037 Disable and reset: quantum_val = 0 -> IDLE, no irq for 1000 cycles; rst asserted in PENDING -> all outputs 0 on the next cycle.
